// File: rtl/encrypt_stream.sv
// encrypt_stream: sequential LWE encryption engine.
//
// Streams the public key in, LANES entries per beat and row by row for rows
// 0..DIMENSION. For each row it sums, mod q, the key entries whose
// noise_select bit is set. On the final (b) row it also adds (q/p)*m. It
// emits one ciphertext element per row on a valid/ready interface.
//
// Optional feature: define ENCRYPT_ABORT_EN to add the 'abort' input.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   abort              (ENCRYPT_ABORT_EN only) return to IDLE, discard op
//   start              begin encryption, sampled only in IDLE
//   plaintext          message m, latched on start
//   noise_select       BIG_N-bit subset mask, latched on start
//   busy               high whenever the engine is not IDLE
//   key_valid/ready    key beat handshake
//   key_data           LANES key entries; lane 0 in the LSBs
//   ct_valid/ready     ciphertext element handshake
//   ct_data            ciphertext element (< q)
//   ct_row             row index of ct_data
//   ct_last            high with the row-DIMENSION element
//   done               one-cycle pulse after the last element is accepted
module encrypt_stream #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int DIMENSION          = 1,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 21,
  parameter int BIG_N              = 30,
  parameter int LANES              = 1,
  localparam int ROW_W = ($clog2(DIMENSION + 1) > 1) ? $clog2(DIMENSION + 1) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
`ifdef ENCRYPT_ABORT_EN
  input  logic                              abort,
`endif
  input  logic                              start,
  input  logic [PLAINTEXT_WIDTH-1:0]        plaintext,
  input  logic [BIG_N-1:0]                  noise_select,
  output logic                              busy,
  input  logic                              key_valid,
  output logic                              key_ready,
  input  logic [LANES*CIPHERTEXT_WIDTH-1:0] key_data,
  output logic                              ct_valid,
  input  logic                              ct_ready,
  output logic [CIPHERTEXT_WIDTH-1:0]       ct_data,
  output logic [ROW_W-1:0]                  ct_row,
  output logic                              ct_last,
  output logic                              done
);

  localparam int CW     = CIPHERTEXT_WIDTH;
  localparam int BEATS  = BIG_N / LANES;
  localparam int BEAT_W = ($clog2(BEATS) > 1) ? $clog2(BEATS) : 1;
  localparam int DELTA  = CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS;

  // One extra bit so q = 2^CW is representable and sums never overflow.
  localparam logic [CW:0]        Q         = (CW + 1)'(CIPHERTEXT_MODULUS);
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(DIMENSION);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_EMIT
  } state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              acc_q;
  logic [BEAT_W-1:0]          beat_q;
  logic [ROW_W-1:0]           row_q;
  logic [PLAINTEXT_WIDTH-1:0] m_q;
  logic [BIG_N-1:0]           mask_q;
  logic [CW-1:0]              ct_data_q;
  logic                       done_q;

  logic                       abort_req;
  logic                       abort_now;
  logic                       key_fire;
  logic                       ct_fire;
  logic                       last_row;
  logic [BIG_N-1:0]           mask_sh;
  logic [CW:0]                lane_sum;
  logic [CW-1:0]              acc_sum;
  logic [CW:0]                scaled_sum;
  logic [CW-1:0]              ct_next;

`ifdef ENCRYPT_ABORT_EN
  always_comb abort_req = abort;
`else
  always_comb abort_req = 1'b0;
`endif

  always_comb begin
    abort_now = abort_req && (state_q != S_IDLE);
    key_fire  = (state_q == S_ACCUM) && key_valid;
    ct_fire   = (state_q == S_EMIT) && ct_ready;
    last_row  = (row_q == LAST_ROW);
  end

  // Lanes are folded in order, each add followed by a conditional subtract,
  // so the running value never leaves [0, q).
  always_comb begin
    mask_sh  = mask_q >> (int'(beat_q) * LANES);
    acc_sum  = acc_q;
    lane_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (mask_sh[i]) begin
        lane_sum = {1'b0, acc_sum} + {1'b0, key_data[i*CW +: CW]};
        if (lane_sum >= Q) begin
          lane_sum = lane_sum - Q;
        end
        acc_sum = lane_sum[CW-1:0];
      end
    end
  end

  // (q/p)*m < q, so a single conditional subtract reduces the b-row sum.
  always_comb begin
    scaled_sum = {1'b0, acc_sum} + (CW + 1)'(DELTA * int'(m_q));
    if (scaled_sum >= Q) begin
      scaled_sum = scaled_sum - Q;
    end
    ct_next = last_row ? scaled_sum[CW-1:0] : acc_sum;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM;
      S_ACCUM: if (key_valid && (beat_q == LAST_BEAT)) state_d = S_EMIT;
      S_EMIT:  if (ct_ready) state_d = last_row ? S_IDLE : S_ACCUM;
      default: state_d = S_IDLE;
    endcase
    if (abort_now) begin
      state_d = S_IDLE;
    end
  end

  // Output logic
  always_comb begin
    busy      = (state_q != S_IDLE);
    key_ready = (state_q == S_ACCUM);
    ct_valid  = (state_q == S_EMIT);
    ct_last   = (state_q == S_EMIT) && last_row;
    ct_data   = ct_data_q;
    ct_row    = row_q;
    done      = done_q;
  end

  // Datapath: accumulator, counters, latched operands and emitted element.
  // ct_data_q is captured on the final beat so it holds steady through EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      beat_q    <= '0;
      row_q     <= '0;
      m_q       <= '0;
      mask_q    <= '0;
      ct_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= ct_fire && last_row && !abort_now;
      if (abort_now) begin
        acc_q  <= '0;
        beat_q <= '0;
        row_q  <= '0;
      end else begin
        if (state_q == S_IDLE && start) begin
          m_q    <= plaintext;
          mask_q <= noise_select;
          acc_q  <= '0;
          beat_q <= '0;
          row_q  <= '0;
        end
        if (key_fire) begin
          acc_q <= acc_sum;
          if (beat_q == LAST_BEAT) begin
            beat_q    <= '0;
            ct_data_q <= ct_next;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        if (ct_fire && !last_row) begin
          row_q  <= row_q + 1'b1;
          acc_q  <= '0;
          beat_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_encrypt_stream.sv
module tb_encrypt_stream;

  localparam int N  = 4;
  localparam int D  = 1;
  localparam int Q  = 1024;
  localparam int P  = 64;
  localparam int W  = 21;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    start;
  logic [PW-1:0] plaintext;
  logic [N-1:0]  noise_select;
  logic [1:0]    busy, key_valid, key_ready, ct_valid, ct_ready, ct_last, done;
  logic [0:0]    ct_row0, ct_row1;
  logic [W-1:0]  kd0, ctd0, ctd1;
  logic [2*W-1:0] kd1;
`ifdef ENCRYPT_ABORT_EN
  logic          abort;
`endif

  int checks   = 0;
  int failures = 0;
  int key_tab [0:1][0:3];

  always #5 clk = ~clk;

  encrypt_stream #(
    .PLAINTEXT_MODULUS(P), .PLAINTEXT_WIDTH(PW), .DIMENSION(D),
    .CIPHERTEXT_MODULUS(Q), .CIPHERTEXT_WIDTH(W), .BIG_N(N), .LANES(1)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef ENCRYPT_ABORT_EN
    .abort(abort),
`endif
    .start(start[0]), .plaintext(plaintext), .noise_select(noise_select),
    .busy(busy[0]), .key_valid(key_valid[0]), .key_ready(key_ready[0]),
    .key_data(kd0), .ct_valid(ct_valid[0]), .ct_ready(ct_ready[0]),
    .ct_data(ctd0), .ct_row(ct_row0), .ct_last(ct_last[0]), .done(done[0])
  );

  encrypt_stream #(
    .PLAINTEXT_MODULUS(P), .PLAINTEXT_WIDTH(PW), .DIMENSION(D),
    .CIPHERTEXT_MODULUS(Q), .CIPHERTEXT_WIDTH(W), .BIG_N(N), .LANES(2)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef ENCRYPT_ABORT_EN
    .abort(abort),
`endif
    .start(start[1]), .plaintext(plaintext), .noise_select(noise_select),
    .busy(busy[1]), .key_valid(key_valid[1]), .key_ready(key_ready[1]),
    .key_data(kd1), .ct_valid(ct_valid[1]), .ct_ready(ct_ready[1]),
    .ct_data(ctd1), .ct_row(ct_row1), .ct_last(ct_last[1]), .done(done[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctd(input int d);
    return (d == 0) ? 32'(ctd0) : 32'(ctd1);
  endfunction

  function automatic logic [31:0] crow(input int d);
    return (d == 0) ? 32'(ct_row0) : 32'(ct_row1);
  endfunction

  task automatic chk_idle_outputs(input string tag, input int d);
    chk({tag, ".busy"},      32'(busy[d]), 0);
    chk({tag, ".key_ready"}, 32'(key_ready[d]), 0);
    chk({tag, ".ct_valid"},  32'(ct_valid[d]), 0);
    chk({tag, ".ct_data"},   ctd(d), 0);
    chk({tag, ".ct_row"},    crow(d), 0);
    chk({tag, ".ct_last"},   32'(ct_last[d]), 0);
    chk({tag, ".done"},      32'(done[d]), 0);
  endtask

  // Reference: row r = sum of key_tab[r][c] over mask bits, mod q; b row adds (q/p)*m.
  function automatic int model_row(input int r, input int m, input int mask);
    int s = 0;
    for (int c = 0; c < N; c++)
      if ((mask >> c) & 1) s = (s + key_tab[r][c]) % Q;
    if (r == D) s = (s + (Q / P) * m) % Q;
    return s;
  endfunction

  // intr: 0 = run to completion, 1 = reset mid-ACCUM of row 1, 2 = abort in EMIT of row 0
  task automatic run_op(input int d, input int m, input int mask, input int gap_pct,
                        input int stall, input bit poke, input int intr);
    int lanes = (d == 0) ? 1 : 2;
    int beats = N / lanes;
    int cyc;
    int b;
    int exp_ct;
    bit kv;
    @(negedge clk);
    plaintext    = PW'(m);
    noise_select = N'(mask);
    start[d]     = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    cyc = 0;
    chk("start.busy", 32'(busy[d]), 1);
    for (int r = 0; r <= D; r++) begin
      exp_ct = model_row(r, m, mask);
      b = 0;
      while (b < beats) begin
        if (intr == 1 && r == 1 && b == 1) begin
          rst_n = 1'b0;
          #1;
          chk_idle_outputs("reset_mid_accum", d);
          @(negedge clk);
          key_valid[d] = 1'b0;
          rst_n = 1'b1;
          return;
        end
        chk("accum.key_ready", 32'(key_ready[d]), 1);
        chk("accum.ct_valid",  32'(ct_valid[d]), 0);
        kv = (gap_pct == 0) || (($urandom % 100) >= gap_pct);
        key_valid[d] = kv;
        if (!kv) begin
          kd0 = W'($urandom);
          kd1 = {W'($urandom), W'($urandom)};
        end else if (d == 0) begin
          kd0 = W'(key_tab[r][b]);
        end else begin
          kd1 = {W'(key_tab[r][2*b+1]), W'(key_tab[r][2*b])};
        end
        if (poke && r == 0 && b == 1) begin
          start[d]     = 1'b1;
          plaintext    = ~PW'(m);
          noise_select = ~N'(mask);
        end
        if (kv) b++;
        @(negedge clk);
        cyc++;
        start[d]     = 1'b0;
        plaintext    = PW'($urandom);
        noise_select = N'($urandom);
      end
      // Offer junk beats during EMIT; they must not be consumed.
      key_valid[d] = 1'b1;
      kd0 = W'($urandom);
      kd1 = {W'($urandom), W'($urandom)};
      for (int s = 0; s < stall; s++) begin
        ct_ready[d] = 1'b0;
        chk("stall.ct_valid",  32'(ct_valid[d]), 1);
        chk("stall.key_ready", 32'(key_ready[d]), 0);
        chk("stall.ct_data",   ctd(d), 32'(exp_ct));
        chk("stall.ct_row",    crow(d), 32'(r));
        @(negedge clk);
        cyc++;
      end
      chk("emit.ct_valid",  32'(ct_valid[d]), 1);
      chk("emit.key_ready", 32'(key_ready[d]), 0);
      chk("emit.ct_data",   ctd(d), 32'(exp_ct));
      chk("emit.ct_row",    crow(d), 32'(r));
      chk("emit.ct_last",   32'(ct_last[d]), (r == D) ? 1 : 0);
      chk("emit.ct_lt_q",   32'(ctd(d) < 32'(Q)), 1);
      ct_ready[d] = 1'b1;
`ifdef ENCRYPT_ABORT_EN
      if (intr == 2) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ct_ready[d]  = 1'b0;
        key_valid[d] = 1'b0;
        chk("abort.busy",      32'(busy[d]), 0);
        chk("abort.ct_valid",  32'(ct_valid[d]), 0);
        chk("abort.key_ready", 32'(key_ready[d]), 0);
        chk("abort.done",      32'(done[d]), 0);
        @(negedge clk);
        chk("abort.done_late", 32'(done[d]), 0);
        return;
      end
`endif
      @(negedge clk);
      cyc++;
      ct_ready[d]  = 1'b0;
      key_valid[d] = 1'b0;
    end
    chk("end.done",     32'(done[d]), 1);
    chk("end.busy",     32'(busy[d]), 0);
    chk("end.ct_valid", 32'(ct_valid[d]), 0);
    if (gap_pct == 0 && stall == 0)
      chk("end.latency", 32'(cyc), 32'((D + 1) * (beats + 1)));
    @(negedge clk);
    chk("end.done_pulse", 32'(done[d]), 0);
  endtask

  task automatic load_scenario1();
    key_tab[0] = '{100, 200, 300, 400};
    key_tab[1] = '{10, 20, 30, 40};
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    plaintext = '0;
    noise_select = '0;
    key_valid = '0;
    ct_ready = '0;
    kd0 = '0;
    kd1 = '0;
`ifdef ENCRYPT_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    chk_idle_outputs("reset0", 0);
    chk_idle_outputs("reset1", 1);
    rst_n = 1'b1;

    // Basic: row0 = 400, row1 = 40 + 16*5 = 120, 10 cycles
    load_scenario1();
    chk("model.s1_row0", 32'(model_row(0, 5, 4'b0101)), 400);
    chk("model.s1_row1", 32'(model_row(1, 5, 4'b0101)), 120);
    run_op(0, 5, 4'b0101, 0, 0, 0, 0);

    // Wrap-around: row1 = 2000 mod 1024 = 976
    key_tab[0] = '{1023, 1023, 512, 7};
    key_tab[1] = '{1000, 1000, 0, 0};
    run_op(0, 0, 4'b0011, 0, 0, 0, 0);

    // Backpressure on every element
    load_scenario1();
    run_op(0, 5, 4'b0101, 0, 5, 0, 0);

    // Empty mask, max plaintext, start poked while busy: row0 = 0, row1 = 1008
    run_op(0, 63, 4'b0000, 0, 0, 1, 0);
    run_op(1, 63, 4'b0000, 0, 0, 1, 0);

    // Two lanes: same results, 6-cycle latency, then with key_valid gaps
    run_op(1, 5, 4'b0101, 0, 0, 0, 0);
    run_op(1, 5, 4'b0101, 30, 2, 0, 0);

    // Reset mid-ACCUM, then a clean rerun
    run_op(0, 5, 4'b0101, 0, 0, 0, 1);
    run_op(0, 5, 4'b0101, 0, 0, 0, 0);
    run_op(1, 5, 4'b0101, 0, 0, 0, 1);
    run_op(1, 5, 4'b0101, 0, 0, 0, 0);

`ifdef ENCRYPT_ABORT_EN
    run_op(0, 5, 4'b0101, 0, 0, 0, 2);
    run_op(0, 5, 4'b0101, 0, 0, 0, 0);
`endif

    // Randomized operations on both lane configurations
    for (int it = 0; it < 12; it++) begin
      for (int r = 0; r <= D; r++)
        for (int c = 0; c < N; c++)
          key_tab[r][c] = int'($urandom_range(Q - 1, 0));
      run_op(it % 2, int'($urandom_range(P - 1, 0)), int'($urandom_range(15, 0)),
             25, int'($urandom_range(2, 0)), it % 3 == 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/encrypt_stream.md
Name: encrypt_stream

Overview:
Sequential, parametrised LWE encryption engine and successor to the single-row combinational encrypt block.
- Streams the public key in, LANES entries per beat, row by row for rows 0..DIMENSION.
- For each row, accumulates the entries whose noise_select bit is set, modulo CIPHERTEXT_MODULUS.
- On the final (b) row, adds the scaled plaintext.
- Emits one ciphertext element per row on a valid/ready output.
- Sits between the key-storage reader and the ciphertext buffer.

Parameters:
- PLAINTEXT_MODULUS, 64, p; power of two.
- PLAINTEXT_WIDTH, 6, log2(p).
- DIMENSION, 1, rows 0..DIMENSION-1 are the a-part; row DIMENSION is b.
- CIPHERTEXT_MODULUS, 1024, q; power of two, q >= p, q <= 2^CIPHERTEXT_WIDTH.
- CIPHERTEXT_WIDTH, 21, width of key entries and results.
- BIG_N, 30, number of public key columns (samples).
- LANES, 1, key entries per beat; BIG_N % LANES == 0.
- ROW_W (localparam), max(1, $clog2(DIMENSION+1)).

Ports:
- clk, in, 1, clock; rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin encryption; sampled only in IDLE.
- plaintext, in, PLAINTEXT_WIDTH, message m; latched on start.
- noise_select, in, BIG_N, subset mask; latched on start.
- busy, out, 1, high in any state other than IDLE.
- key_valid, in, 1, key beat valid.
- key_ready, out, 1, engine accepts a key beat.
- key_data, in, LANES*CIPHERTEXT_WIDTH, lane i holds column beat*LANES+i; lane 0 is in the LSBs.
- ct_valid, out, 1, ciphertext element valid.
- ct_ready, in, 1, downstream accepts.
- ct_data, out, CIPHERTEXT_WIDTH, ciphertext element, always < q.
- ct_row, out, ROW_W, row index of ct_data.
- ct_last, out, 1, high with the row-DIMENSION element.
- done, out, 1, one-cycle pulse after the last element is accepted.

Behaviour:
- Reset (asynchronous, any state): FSM=IDLE; accumulator, beat counter and row counter = 0; latched m and mask = 0.
  - Outputs after reset: busy=0, key_ready=0, ct_valid=0, ct_data=0, ct_row=0, ct_last=0, done=0.
  - An in-flight operation is discarded; no done pulse.
- FSM states IDLE -> ACCUM -> EMIT -> (ACCUM | IDLE).
- IDLE:
  - start=1 latches plaintext and noise_select and clears the accumulator, beat counter and row counter; next state ACCUM.
  - start is ignored in every other state.
- ACCUM:
  - key_ready=1. Each cycle with key_valid&&key_ready consumes one beat.
  - For each lane i with mask bit (beat*LANES+i) set: acc = (acc + lane_i) mod q. Apply the lanes sequentially; each add is followed by a conditional subtract of q.
  - Key entries are required < q; out-of-range entries give undefined results.
  - After beat BIG_N/LANES-1, next state EMIT.
- EMIT entry:
  - ct_data = acc for rows below DIMENSION.
  - For row DIMENSION: ct_data = (acc + (q/p)*m) mod q.
  - ct_row = current row; ct_last = (row == DIMENSION); key_ready=0; ct_valid=1.
- EMIT hold: ct_data, ct_row and ct_last stay stable while ct_ready=0.
- EMIT handshake (ct_valid&&ct_ready):
  - If not last row: row++, acc=0, beat=0, next state ACCUM.
  - If last row: ct_valid=0, done=1 for one cycle, next state IDLE.
- Latency: minimum (DIMENSION+1)*(BIG_N/LANES+1) cycles from start to done with no stalls. The first key_ready rises the cycle after start.
- Stalls: key_valid=0 stalls the beat counter; the accumulator is unchanged.
- The mask is held constant for the whole operation; new plaintext and noise_select values have no effect until the next start.

Optional Feature:
ENCRYPT_ABORT_EN
- Defined:
  - Adds port abort (in, 1).
  - abort=1 in any non-IDLE state returns the FSM to IDLE on the next edge and clears the accumulator and counters.
  - ct_valid and key_ready drop; no done pulse.
  - abort has priority over a same-cycle handshake; abort in IDLE has no effect.
- Undefined: the port is absent and an operation always runs to completion or reset.

Test Plan:
- All scenarios use BIG_N=4, DIMENSION=1, q=1024, p=64 (delta=16), unless stated otherwise.
1. Basic, LANES=1: m=5, mask=4'b0101, row0 keys [100,200,300,400], row1 keys [10,20,30,40].
   -> ct row0=400, row1=40+80=120 with ct_last=1; done pulses once; total 10 cycles with no stalls.
2. Wrap-around: m=0, mask=4'b0011, row1 keys [1000,1000,0,0].
   -> row1 ct=976; ct_data < 1024 for every element.
3. Backpressure: hold ct_ready=0 for 5 cycles in EMIT.
   -> ct_data and ct_row stable, key_ready=0, key beats not consumed; resumes correctly on release.
4. Empty mask with max plaintext: mask=0, m=63.
   -> row0=0, row1=1008. A start pulse while busy is ignored: no restart, results unchanged.
5. LANES=2 with scenario 1 vectors.
   -> identical results; 2 beats per row; key_valid gaps extend latency only.
6. Interruptions:
   - Assert rst_n=0 mid-ACCUM of row1 -> all outputs 0 immediately; a fresh start afterwards gives scenario 1 results.
   - With ENCRYPT_ABORT_EN: abort in EMIT -> IDLE, no done, busy=0 next cycle.
